// File: rtl/ucc_state_fsm.sv
// rtl/ucc_state_fsm.sv - tracks entry, exit and interruption of the untrusted code compartment
// Feeds ucc_state/outside_ucc/inst_changed to the downstream stack protection monitor.
module ucc_state_fsm #(
  parameter logic [15:0] UCC_MIN       = 16'hE000,
  parameter logic [15:0] UCC_MAX       = 16'hE3FE,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned IRQ_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        system_reset_n,
  input  logic [15:0] pc,
  input  logic        data_wr,
  input  logic        irq,
  input  logic        ext_violation,
  output logic [1:0]  ucc_state,
  output logic        outside_ucc,
  output logic        inst_changed,
  output logic [15:0] base_pc,
  output logic [2:0]  viol_cause
);

  localparam int unsigned CNT_W = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IRQ_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_NOT = 2'b00,
    ST_IN  = 2'b01,
    ST_IRQ = 2'b10,
    ST_RST = 2'b11
  } state_t;

  state_t           state_q;
  logic [15:0]      prev_pc_q;
  logic [CNT_W-1:0] irq_cnt_q;
  logic [2:0]       viol_q;

  assign outside_ucc  = (pc < UCC_MIN) || (pc > UCC_MAX);
  assign inst_changed = (pc != prev_pc_q);
  assign ucc_state    = state_q;
  assign base_pc      = prev_pc_q;
  assign viol_cause   = viol_q;

  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q   <= ST_RST;
      prev_pc_q <= RESET_HANDLER;
      irq_cnt_q <= '0;
      viol_q    <= 3'b000;
    end else begin
      prev_pc_q <= pc;
      if (ext_violation) begin
        state_q   <= ST_RST;
        viol_q    <= 3'b001;
        irq_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_RST: begin
            if (pc == RESET_HANDLER && !data_wr) state_q <= ST_NOT;
          end
          ST_NOT: begin
            // Any landing inside the compartment other than its first word is a bad entry.
            if (!outside_ucc) begin
              if (pc == UCC_MIN) begin
                state_q <= ST_IN;
              end else begin
                state_q <= ST_RST;
                viol_q  <= 3'b010;
              end
            end
          end
          ST_IN: begin
            if (irq) begin
              state_q   <= ST_IRQ;
              irq_cnt_q <= '0;
            end else if (outside_ucc) begin
              if (prev_pc_q == UCC_MAX) begin
                state_q <= ST_NOT;
              end else begin
                state_q <= ST_RST;
                viol_q  <= 3'b011;
              end
            end
          end
          ST_IRQ: begin
            // A return may land anywhere in the compartment; nested irqs do not restart the count.
            if (!outside_ucc && inst_changed) begin
              state_q   <= ST_IN;
              irq_cnt_q <= '0;
            end else if (irq_cnt_q == CNT_LAST) begin
              state_q <= ST_RST;
              viol_q  <= 3'b100;
            end else if (irq_cnt_q != CNT_MAX) begin
              irq_cnt_q <= irq_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ucc_state_fsm.sv
// tb/tb_ucc_state_fsm.sv - scoreboard bench for ucc_state_fsm with directed and random stimulus
module tb_ucc_state_fsm;

  localparam logic [15:0] P_MIN = 16'hE000;
  localparam logic [15:0] P_MAX = 16'hE3FE;
  localparam logic [15:0] P_RH  = 16'h0000;
  localparam int          P_TO  = 1024;

  logic        clk = 1'b0;
  logic        system_reset_n = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        data_wr = 1'b0;
  logic        irq = 1'b0;
  logic        ext_violation = 1'b0;
  logic [1:0]  ucc_state;
  logic        outside_ucc;
  logic        inst_changed;
  logic [15:0] base_pc;
  logic [2:0]  viol_cause;

  ucc_state_fsm #(
    .UCC_MIN(P_MIN), .UCC_MAX(P_MAX), .RESET_HANDLER(P_RH), .IRQ_TIMEOUT(P_TO)
  ) dut (
    .clk(clk), .system_reset_n(system_reset_n), .pc(pc), .data_wr(data_wr),
    .irq(irq), .ext_violation(ext_violation), .ucc_state(ucc_state),
    .outside_ucc(outside_ucc), .inst_changed(inst_changed), .base_pc(base_pc),
    .viol_cause(viol_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic [2:0]  cause;
    logic        outside;
    logic        changed;
    logic [15:0] base;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model: mode 0 outside, 1 in compartment, 2 servicing irq, 3 locked in reset.
  int          m_mode  = 3;
  int          m_cause = 0;
  int          m_age   = 0;
  logic [15:0] m_prev  = P_RH;

  function automatic bit in_ucc(input logic [15:0] p);
    return (p >= P_MIN) && (p <= P_MAX);
  endfunction

  task automatic step(input logic [15:0] p, input logic wr, input logic iq,
                      input logic ev, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    pc = p; data_wr = wr; irq = iq; ext_violation = ev; system_reset_n = rn;
    cyc++;
    if (!rn) begin
      m_mode = 3; m_cause = 0; m_age = 0; m_prev = P_RH;
    end
    e.st = 2'(m_mode); e.cause = 3'(m_cause); e.outside = !in_ucc(p);
    e.changed = (p != m_prev); e.base = m_prev;
    exp_q.push_back(e);
    if (rn) begin
      if (ev) begin
        m_mode = 3; m_cause = 1;
      end else if (m_mode == 3) begin
        if (p == P_RH && !wr) m_mode = 0;
      end else if (m_mode == 0) begin
        if (in_ucc(p)) begin
          if (p == P_MIN) m_mode = 1;
          else begin m_mode = 3; m_cause = 2; end
        end
      end else if (m_mode == 1) begin
        if (iq) begin m_mode = 2; m_age = 0; end
        else if (!in_ucc(p)) begin
          if (m_prev == P_MAX) m_mode = 0;
          else begin m_mode = 3; m_cause = 3; end
        end
      end else begin
        if (in_ucc(p) && p != m_prev) m_mode = 1;
        else begin
          m_age++;
          if (m_age >= P_TO) begin m_mode = 3; m_cause = 4; end
        end
      end
      m_prev = p;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ucc_state", int'(ucc_state), int'(e.st));
        chk("viol_cause", int'(viol_cause), int'(e.cause));
        chk("outside_ucc", int'(outside_ucc), int'(e.outside));
        chk("inst_changed", int'(inst_changed), int'(e.changed));
        chk("base_pc", int'(base_pc), int'(e.base));
      end
    end
  end

  task automatic go_not();
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic enter_ucc();
    step(16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hE000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hE100, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic enter_irq();
    enter_ucc();
    step(16'hFFE0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin : driver
    logic [15:0] rp;
    logic [15:0] lastp;
    step(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    go_not();
    step(16'h4000, 1'b0, 1'b1, 1'b0, 1'b1);
    step(16'hE000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hE3FE, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'h4002, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hE010, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hE010, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_ucc();
    step(16'h5000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'h5002, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_irq();
    for (int i = 0; i < 50; i++) step(16'hFFE0, 1'b0, (i == 10), 1'b0, 1'b1);
    step(16'hE104, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hE106, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < P_TO + 4; i++) step(16'hFFE0, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    step(16'h4000, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_ucc();
    step(16'hE102, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16'hE102, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_irq();
    step(16'hFFE2, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16'hFFE2, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_ucc();
    step(16'hE102, 1'b0, 1'b1, 1'b1, 1'b1);
    step(16'hE102, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_ucc();
    step(16'hE3FE, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'h4000, 1'b0, 1'b0, 1'b1, 1'b1);
    step(16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_irq();
    for (int i = 0; i < 300; i++) step(16'hFFE0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'hFFE0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(16'hFFE0, 1'b0, 1'b0, 1'b0, 1'b1);
    go_not();
    enter_irq();
    for (int i = 0; i < P_TO + 2; i++) step(16'hFFE0, 1'b0, 1'b0, 1'b0, 1'b1);
    lastp = 16'h0000;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 9))
        0: rp = 16'h0000;
        1: rp = P_MIN;
        2: rp = P_MAX;
        3: rp = 16'h4000 + 16'($urandom_range(0, 255));
        4: rp = P_MIN + 16'($urandom_range(0, 16'h3FE));
        5: rp = 16'hFFFF;
        6: rp = lastp;
        7: rp = lastp + 16'h0002;
        8: rp = 16'hE3FF;
        default: rp = 16'hDFFF;
      endcase
      step(rp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) != 0));
      lastp = rp;
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
